// File: rtl/crc8_receiver.sv
// CRC-8 codeword checker: divides {payload, crc} bit-serially MSB first and reports pass/fail.
// Optional failed-codeword counter on err_cnt when CRC_ERR_CNT_EN is defined.
module crc8_receiver #(
    parameter int unsigned BW     = 40,
    parameter int unsigned CRC_BW = 8,
    parameter logic [7:0]  POLY   = 8'h07
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [BW+CRC_BW-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [BW-1:0]          out_data,
    output logic                   out_ok,
    output logic                   out_valid,
`ifdef CRC_ERR_CNT_EN
    output logic [15:0]            err_cnt,
`endif
    input  logic                   out_ready
);

    localparam int unsigned CW    = BW + CRC_BW;
    localparam int unsigned CNT_W = $clog2(CW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       sreg_q, sreg_d;
    logic [BW-1:0]       payload_q, payload_d;
    logic [CRC_BW-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_d;
    logic                out_valid_d;
    logic                out_ok_d;
    logic [BW-1:0]       out_data_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            payload_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_ok    <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            payload_q <= payload_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_ok    <= out_ok_d;
            out_data  <= out_data_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        payload_d   = payload_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_ok_d    = out_ok;
        out_data_d  = out_data;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    sreg_d     = in_data;
                    payload_d  = in_data[CW-1:CRC_BW];
                    rem_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CHECK;
                end
            end

            CHECK: begin
                in_ready_d = 1'b0;
                rem_d  = {rem_q[CRC_BW-2:0], sreg_q[CW-1]}
                       ^ (rem_q[CRC_BW-1] ? POLY : CRC_BW'(0));
                sreg_d = {sreg_q[CW-2:0], 1'b0};
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                in_ready_d = 1'b0;
                // First DONE cycle publishes the result; later cycles hold it until accepted
                if (!out_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = payload_q;
                    out_ok_d    = (rem_q == '0);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

`ifdef CRC_ERR_CNT_EN
    // Saturating count of failed codewords, bumped on the result-publish cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (state_q == DONE && !out_valid && rem_q != '0 && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc8_receiver.sv
// Directed, table-driven bench for crc8_receiver plus stall, reset and in_valid-noise sequences.
module tb_crc8_receiver;

    localparam int unsigned BW  = 40;
    localparam int unsigned CW  = 48;
    localparam int          LAT = 49;

    logic          clk;
    logic          rstn;
    logic [CW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] out_data;
    logic          out_ok;
    logic          out_valid;
    logic          out_ready;
`ifdef CRC_ERR_CNT_EN
    logic [15:0]   err_cnt;
    int            exp_err;
`endif

    int checks;
    int failures;

    crc8_receiver dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ok    (out_ok),
        .out_valid (out_valid),
`ifdef CRC_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [CW-1:0] cw;
        logic [BW-1:0] exp_data;
        logic          exp_ok;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Handshake one codeword; returns just after the accepting edge
    task automatic start(input logic [CW-1:0] cw);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end
        in_valid = 1'b1;
        in_data  = cw;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count rising edges until out_valid is seen high
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 200);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start(v.cw);
        wait_out(lat);
        chk({v.name, "_lat"},  64'(lat),      64'(LAT));
        chk({v.name, "_data"}, 64'(out_data), 64'(v.exp_data));
        chk({v.name, "_ok"},   64'(out_ok),   64'(v.exp_ok));
`ifdef CRC_ERR_CNT_EN
        if (!v.exp_ok) exp_err++;
        chk({v.name, "_err"},  64'(err_cnt),  64'(exp_err));
`endif
        @(negedge clk);
        chk({v.name, "_release"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int pre;
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef CRC_ERR_CNT_EN
        exp_err   = 0;
`endif

        vecs[0] = '{"one_ok",    48'h0000_0000_0107, 40'h00_0000_0001, 1'b1};
        vecs[1] = '{"one_flip",  48'h0000_0000_0106, 40'h00_0000_0001, 1'b0};
        vecs[2] = '{"zero",      48'h0000_0000_0000, 40'h00_0000_0000, 1'b1};
        vecs[3] = '{"b100_ok",   48'h0000_0001_0015, 40'h00_0000_0100, 1'b1};
        vecs[4] = '{"b100_bad",  48'h0000_0001_0014, 40'h00_0000_0100, 1'b0};
        vecs[5] = '{"b80_ok",    48'h0000_0000_8089, 40'h00_0000_0080, 1'b1};
        vecs[6] = '{"bff_ok",    48'h0000_0000_fff3, 40'h00_0000_00ff, 1'b1};
        vecs[7] = '{"msb_flip",  48'h8000_0000_0107, 40'h80_0000_0001, 1'b0};
        vecs[8] = '{"crc_only",  48'h0000_0000_0001, 40'h00_0000_0000, 1'b0};
        vecs[9] = '{"poly_x39",  48'h8380_0000_0000, 40'h83_8000_0000, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {22'd0, in_ready, out_valid, out_ok, out_data}, 64'd0);
`ifdef CRC_ERR_CNT_EN
        chk("rst_err", 64'(err_cnt), 64'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_rise", 64'(in_ready), 64'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Consumer stall: outputs hold, no new codeword accepted
        out_ready = 1'b0;
        start(48'h0000_0001_0015);
        wait_out(lat);
        chk("stall_lat", 64'(lat), 64'(LAT));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold", {22'd0, in_ready, out_valid, out_ok, out_data},
                {22'd0, 1'b0, 1'b1, 1'b1, 40'h00_0000_0100});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", {62'd0, out_valid, in_ready}, 64'b01);

        // in_valid noise during CHECK must not disturb the in-flight codeword
        start(48'h0000_0000_0106);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_data  = 48'h0000_0000_0107;
        end
        in_valid = 1'b0;
        pre = 9;
        wait_out(lat);
        chk("noise_lat",  64'(pre + lat), 64'(LAT));
        chk("noise_data", 64'(out_data),  64'h1);
        chk("noise_ok",   64'(out_ok),    64'd0);
`ifdef CRC_ERR_CNT_EN
        exp_err++;
        chk("noise_err",  64'(err_cnt),   64'(exp_err));
`endif
        @(negedge clk);

        // Reset in the middle of CHECK
        start(48'h0000_0000_0106);
        repeat (20) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_outs", {62'd0, out_valid, in_ready}, 64'd0);
`ifdef CRC_ERR_CNT_EN
        exp_err = 0;
        chk("midrst_err", 64'(err_cnt), 64'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
